// File: rtl/nn_layer_seq.sv
// Fully-connected layer computed one multiply-accumulate per cycle, with saturating activation.
// Optional feature: define NN_LAYER_RELU_EN to clip negative results to zero (ReLU).
module nn_layer_seq #(
  parameter int unsigned N_IN  = 12,
  parameter int unsigned N_OUT = 15,
  parameter int unsigned IN_W  = 10,
  parameter int unsigned W_W   = 10,
  parameter int unsigned OUT_W = 11,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned ACC_W = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_IN*IN_W-1:0]                in_vec,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                w_we,
  input  logic [$clog2(N_OUT*(N_IN+1))-1:0]   w_addr,
  input  logic [W_W-1:0]                      w_data,
  output logic [N_OUT*OUT_W-1:0]              out_vec,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy
);

  localparam int unsigned NCoef = N_OUT * (N_IN + 1);
  localparam int unsigned AW    = $clog2(NCoef);
  localparam int unsigned JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned KW    = $clog2(N_IN + 1);
  localparam int unsigned PW    = IN_W + W_W;

  localparam logic [JW-1:0] JLast = JW'(N_OUT - 1);
  localparam logic [KW-1:0] KLast = KW'(N_IN);

  localparam logic signed [ACC_W-1:0] YMax = ACC_W'((longint'(1) <<< (OUT_W - 1)) - longint'(1));
  localparam logic signed [ACC_W-1:0] YMin = ACC_W'(-(longint'(1) <<< (OUT_W - 1)));

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [JW-1:0]           j_q, j_d;
  logic [KW-1:0]           k_q, k_d;
  logic [AW-1:0]           idx_q, idx_d;

  logic signed [IN_W-1:0]  x_q    [N_IN];
  logic signed [W_W-1:0]   coef_q [NCoef];
  logic signed [OUT_W-1:0] y_q    [N_OUT];

  logic                    x_we, y_we, coef_we;
  logic signed [IN_W-1:0]  x_cur;
  logic signed [W_W-1:0]   w_cur;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext, bias_ext, t_sum, t_val;
  logic signed [OUT_W-1:0] y_new;

  // idx_q tracks j*(N_IN+1)+k, so at k == N_IN the same read port yields the bias.
  always_comb begin
    x_cur    = (k_q == KLast) ? '0 : x_q[k_q];
    w_cur    = coef_q[idx_q];
    prod     = PW'(x_cur) * PW'(w_cur);
    prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};
    bias_ext = {{(ACC_W - W_W){w_cur[W_W-1]}}, w_cur};
    t_sum    = acc_q + (bias_ext <<< FRAC);
    t_val    = t_sum >>> FRAC;
    if (t_val > YMax) begin
      y_new = YMax[OUT_W-1:0];
`ifdef NN_LAYER_RELU_EN
    end else if (t_val[ACC_W-1]) begin
      y_new = '0;
`else
    end else if (t_val < YMin) begin
      y_new = YMin[OUT_W-1:0];
`endif
    end else begin
      y_new = t_val[OUT_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    j_d     = j_q;
    k_d     = k_q;
    idx_d   = idx_q;
    x_we    = 1'b0;
    y_we    = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StMac;
          acc_d   = '0;
          j_d     = '0;
          k_d     = '0;
          idx_d   = '0;
          x_we    = 1'b1;
        end
      end
      StMac: begin
        idx_d = idx_q + AW'(1);
        if (k_q != KLast) begin
          acc_d = acc_q + prod_ext;
          k_d   = k_q + KW'(1);
        end else begin
          y_we  = 1'b1;
          acc_d = '0;
          k_d   = '0;
          j_d   = j_q + JW'(1);
          if (j_q == JLast) begin
            state_d = StDone;
            j_d     = '0;
            idx_d   = '0;
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StMac);
  assign out_valid = (state_q == StDone);
  // Coefficients are frozen while a vector is being computed.
  assign coef_we   = w_we && (state_q != StMac) && (32'(w_addr) < NCoef);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      j_q     <= j_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_IN); i++) x_q[i] <= '0;
      for (int i = 0; i < int'(NCoef); i++) coef_q[i] <= '0;
      for (int i = 0; i < int'(N_OUT); i++) y_q[i] <= '0;
    end else begin
      if (x_we) begin
        for (int i = 0; i < int'(N_IN); i++) x_q[i] <= in_vec[i*IN_W +: IN_W];
      end
      if (coef_we) coef_q[w_addr] <= w_data;
      if (y_we) y_q[j_q] <= y_new;
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign out_vec[g*OUT_W +: OUT_W] = y_q[g];
  end

endmodule

// File: tb/tb_nn_layer_seq.sv
// Self-checking bench for nn_layer_seq: transaction-level reference model plus directed checks.
module tb_nn_layer_seq;

  localparam int N_IN  = 12;
  localparam int N_OUT = 15;
  localparam int IN_W  = 10;
  localparam int W_W   = 10;
  localparam int OUT_W = 11;
  localparam int FRAC  = 8;
  localparam int ACC_W = 32;
  localparam int NCOEF = N_OUT * (N_IN + 1);
  localparam int AW    = $clog2(NCOEF);
  localparam int HI    = (1 << (OUT_W - 1)) - 1;
`ifdef NN_LAYER_RELU_EN
  localparam int LO    = 0;
`else
  localparam int LO    = -(1 << (OUT_W - 1));
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [N_IN*IN_W-1:0]     in_vec;
  logic                     in_valid;
  logic                     in_ready;
  logic                     w_we;
  logic [AW-1:0]            w_addr;
  logic [W_W-1:0]           w_data;
  logic [N_OUT*OUT_W-1:0]   out_vec;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;

  nn_layer_seq #(
    .N_IN(N_IN), .N_OUT(N_OUT), .IN_W(IN_W), .W_W(W_W),
    .OUT_W(OUT_W), .FRAC(FRAC), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .out_vec(out_vec), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dut_y(int j);
    logic signed [OUT_W-1:0] s;
    s = out_vec[j*OUT_W +: OUT_W];
    return int'(s);
  endfunction

  function automatic int in_x(int k);
    logic signed [IN_W-1:0] s;
    s = in_vec[k*IN_W +: IN_W];
    return int'(s);
  endfunction

  // Reference model: coefficient table, latched inputs, and a phase with a latency counter.
  int mcoef [NCOEF];
  int mx    [N_IN];
  int exp_y [N_OUT];
  int mstate;  // 0 idle, 1 computing, 2 result held
  int mcnt;

  function automatic int neuron(int j);
    longint acc = 0;
    longint t;
    int     base = j * (N_IN + 1);
    for (int k = 0; k < N_IN; k++) acc += longint'(mx[k]) * longint'(mcoef[base + k]);
    t = acc + longint'(mcoef[base + N_IN]) * (longint'(1) << FRAC);
    t = t >>> FRAC;
    if (t > HI) return HI;
    if (t < LO) return LO;
    return int'(t);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mstate <= 0;
      mcnt   <= 0;
      for (int i = 0; i < NCOEF; i++) mcoef[i] <= 0;
      for (int j = 0; j < N_OUT; j++) exp_y[j] <= 0;
    end else begin
      if (w_we && mstate != 1 && int'(w_addr) < NCOEF) mcoef[w_addr] <= int'($signed(w_data));
      case (mstate)
        0: if (in_valid) begin
          for (int k = 0; k < N_IN; k++) mx[k] <= in_x(k);
          mcnt   <= 0;
          mstate <= 1;
        end
        1: begin
          if (mcnt == NCOEF - 1) begin
            for (int j = 0; j < N_OUT; j++) exp_y[j] <= neuron(j);
            mstate <= 2;
          end else begin
            mcnt <= mcnt + 1;
          end
        end
        default: if (out_ready) mstate <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, mstate == 0);
      chk("busy", busy, mstate == 1);
      chk("out_valid", out_valid, mstate == 2);
      if (mstate == 2) begin
        for (int j = 0; j < N_OUT; j++) chk($sformatf("y%0d", j), dut_y(j), exp_y[j]);
      end
    end
  end

  int xs [N_IN];

  task automatic wr(input int addr, input int val);
    w_we   = 1'b1;
    w_addr = addr[AW-1:0];
    w_data = val[W_W-1:0];
    @(negedge clk);
    w_we   = 1'b0;
  endtask

  task automatic fill(input int wv, input int bv);
    for (int a = 0; a < NCOEF; a++) wr(a, ((a % (N_IN + 1)) == N_IN) ? bv : wv);
  endtask

  task automatic start_vec();
    for (int k = 0; k < N_IN; k++) in_vec[k*IN_W +: IN_W] = xs[k][IN_W-1:0];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, input bit junk);
    lat = 0;
    while (!out_valid && lat < 1000) begin
      if (junk) begin
        w_we     = 1'($urandom_range(0, 1));
        w_addr   = AW'($urandom);
        w_data   = W_W'($urandom);
        in_valid = 1'($urandom_range(0, 1));
        for (int k = 0; k < N_IN; k++) in_vec[k*IN_W +: IN_W] = IN_W'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    w_we     = 1'b0;
    in_valid = 1'b0;
    if (!out_valid) chk("done_timeout", out_valid, 1);
  endtask

  task automatic ack(input int d);
    repeat (d) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  ok;
    logic [N_OUT*OUT_W-1:0] snap;

    in_vec = '0; in_valid = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0; out_ready = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    for (int j = 0; j < N_OUT; j++) chk("rst_y", dut_y(j), 0);

    // Unit weights in Q.8, unit inputs: every neuron sums to 12.
    fill(256, 0);
    for (int k = 0; k < N_IN; k++) xs[k] = 1;
    start_vec();
    wait_done(lat, 1'b0);
    chk("latency", lat, 195);
    for (int j = 0; j < N_OUT; j++) chk("y_ones", dut_y(j), 12);
    chk("model_pin", exp_y[N_OUT-1], 12);

    // Result must hold while downstream stalls.
    snap = out_vec;
    ok   = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_vec !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
    end
    chk("hold_stable", ok, 1);
    ack(0);
    chk("ack_in_ready", in_ready, 1);

    // Bias write during computation is dropped; the same write while idle takes effect.
    start_vec();
    wr(N_IN, 100);
    wait_done(lat, 1'b0);
    chk("mac_write_ignored", dut_y(0), 12);
    ack(2);
    wr(N_IN, 100);
    start_vec();
    wait_done(lat, 1'b0);
    chk("idle_write_y0", dut_y(0), 112);
    chk("idle_write_y1", dut_y(1), 12);
    ack(1);

    fill(511, 0);
    for (int k = 0; k < N_IN; k++) xs[k] = 511;
    start_vec();
    wait_done(lat, 1'b0);
    for (int j = 0; j < N_OUT; j++) chk("sat_pos", dut_y(j), 1023);
    ack(0);

    fill(-511, 0);
    start_vec();
    wait_done(lat, 1'b0);
`ifdef NN_LAYER_RELU_EN
    for (int j = 0; j < N_OUT; j++) chk("sat_neg_relu", dut_y(j), 0);
`else
    for (int j = 0; j < N_OUT; j++) chk("sat_neg", dut_y(j), -1024);
`endif
    ack(0);

    // Randomized vectors; junk writes and valids are driven throughout the computation.
    for (int it = 0; it < 10; it++) begin
      for (int a = 0; a < NCOEF; a++) begin
        if ((a % (N_IN + 1)) == N_IN) wr(a, int'($urandom_range(0, 1022)) - 511);
        else if (it % 3 == 0)         wr(a, int'($urandom_range(0, 1022)) - 511);
        else                          wr(a, int'($urandom_range(0, 80)) - 40);
      end
      wr(NCOEF + int'($urandom_range(0, (1 << AW) - 1 - NCOEF)), int'($urandom_range(0, 511)));
      for (int k = 0; k < N_IN; k++) xs[k] = int'($urandom_range(0, 1023)) - 512;
      start_vec();
      wait_done(lat, 1'b1);
      chk("rand_latency", lat, NCOEF);
      ack(int'($urandom_range(0, 5)));
    end

    // Reset in the middle of a computation.
    fill(256, 5);
    for (int k = 0; k < N_IN; k++) xs[k] = 1;
    start_vec();
    repeat (49) @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    for (int j = 0; j < N_OUT; j++) chk("mid_rst_y", dut_y(j), 0);
    ok = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    chk("mid_rst_no_valid", ok, 1);
    for (int k = 0; k < N_IN; k++) xs[k] = 100 + k;
    start_vec();
    wait_done(lat, 1'b0);
    for (int j = 0; j < N_OUT; j++) chk("coef_cleared", dut_y(j), 0);
    ack(0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_layer_seq.md
NN_LAYER_SEQ -- requirements
Module: nn_layer_seq

Interface
REQ-001 Parameter N_IN, default 12: input count per neuron.
REQ-002 Parameter N_OUT, default 15: neuron count.
REQ-003 Parameter IN_W, default 10: signed input width.
REQ-004 Parameter W_W, default 10: signed weight/bias width.
REQ-005 Parameter OUT_W, default 11: signed output width.
REQ-006 Parameter FRAC, default 8: weight fractional bits, i.e. the post-accumulate right shift.
REQ-007 Parameter ACC_W, default 32: signed accumulator width.
REQ-008 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-009 Port rst, input, 1: reset, asynchronous and active-high.
REQ-010 Port in_vec, input, N_IN*IN_W: packed inputs; x[k] = bits [k*IN_W +: IN_W].
REQ-011 Port in_valid, input, 1: in_vec valid.
REQ-012 Port in_ready, output, 1: block can accept a vector.
REQ-013 Port w_we, input, 1: coefficient write strobe.
REQ-014 Port w_addr, input, clog2(N_OUT*(N_IN+1)): coefficient address = j*(N_IN+1)+k; k=N_IN selects bias of neuron j.
REQ-015 Port w_data, input, W_W: signed coefficient.
REQ-016 Port out_vec, output, N_OUT*OUT_W: packed results; y[j] = bits [j*OUT_W +: OUT_W].
REQ-017 Port out_valid, output, 1: out_vec valid.
REQ-018 Port out_ready, input, 1: downstream accepts out_vec.
REQ-019 Port busy, output, 1: high in state MAC.

Function
REQ-020 The FSM SHALL have states IDLE, MAC and DONE.
REQ-021 IDLE: in_ready=1; on in_valid&in_ready the block SHALL latch in_vec, clear acc, set j=0, k=0, and go to MAC.
REQ-022 MAC, k<N_IN: acc += x[k]*w[j][k] (full-precision signed product, sign-extended to ACC_W), then k++.
REQ-023 MAC, k=N_IN: the block SHALL compute t = (acc + (bias[j] << FRAC)) >>> FRAC (arithmetic shift, floor), apply the activation (REQ-030), write y[j], clear acc, set k=0, j++.
REQ-024 After y[N_OUT-1] is written, the FSM SHALL go to DONE; latency from accept to out_valid SHALL be exactly N_OUT*(N_IN+1) cycles.
REQ-025 DONE: out_valid=1 and out_vec SHALL be held stable until out_valid&out_ready, then the FSM SHALL return to IDLE; in_ready=0 in DONE.
REQ-026 in_ready SHALL be 0 in MAC; in_valid SHALL be ignored there.
REQ-027 w_we SHALL write the coefficient in IDLE and DONE and SHALL be ignored in MAC, so coefficients are frozen during a computation.
REQ-028 A w_we with w_addr >= N_OUT*(N_IN+1) SHALL be ignored.
REQ-029 y registers SHALL change only at their REQ-023 write; a new result vector overwrites all of them.
REQ-030 Activation: t SHALL be saturated to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].

Reset
REQ-031 rst SHALL force state IDLE, acc=0, j=0, k=0, all y=0, out_valid=0, busy=0, in_ready=1 (after release).
REQ-032 Reset mid-MAC SHALL abandon the computation without producing out_valid.
REQ-033 Coefficient storage SHALL be cleared to 0 by rst.

Configuration
REQ-034 Macro NN_LAYER_RELU_EN: when defined, a negative saturated t SHALL become 0 (ReLU clip range [0, 2^(OUT_W-1)-1]).
REQ-035 Without NN_LAYER_RELU_EN, the activation SHALL be symmetric saturation only, per REQ-030.

Verification
REQ-036 Defaults; all weights 256, biases 0, all x=1 -> after 195 cycles out_valid=1 and every y=12.
REQ-037 Weights 511, x=511 -> every y=1023 (positive saturation).
REQ-038 Weights -511, x=511 -> every y=-1024 without NN_LAYER_RELU_EN, every y=0 with it.
REQ-039 Hold out_ready=0 for 20 cycles in DONE -> out_vec stable, in_ready=0; pulse out_ready -> IDLE, in_ready=1.
REQ-040 w_we during MAC (bias[0]:=100) -> ignored, result unchanged; same write in IDLE -> the next y[0] increases by 100 (before saturation).
REQ-041 Assert rst at cycle 50 of MAC -> out_valid never rises, y=0, coefficients=0, in_ready=1 after release.
